// File: rtl/ltl_monitor_cluster_ctrl.sv
// Per-cluster LTL monitor: reduces automaton report states into live/sticky verdicts,
// saturating violation counters and a single-entry timestamped first-hit event port.
module ltl_monitor_cluster_ctrl #(
    parameter  int NUM_PROPS      = 10,
    parameter  int NUM_REPORTS    = 4,
    parameter  int CNT_W          = 8,
    parameter  int TS_W           = 32,
    parameter  int FREEZE_ON_VIOL = 0,
    localparam int ID_W           = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               run,
    input  logic                               clear,
    input  logic [NUM_PROPS-1:0]               prop_en,
    input  logic [NUM_PROPS*NUM_REPORTS-1:0]   rpt_in,
    output logic [NUM_PROPS-1:0]               ltl_out,
    output logic [NUM_PROPS-1:0]               ltl_sticky,
    output logic [NUM_PROPS*CNT_W-1:0]         viol_cnt,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic [ID_W-1:0]                    evt_id,
    output logic [TS_W-1:0]                    evt_time,
    output logic                               evt_multi,
    output logic                               evt_lost,
    output logic                               frozen
);

    typedef enum logic {ACTIVE, FROZEN} state_e;

    state_e                       state_q, state_d;
    logic [NUM_PROPS-1:0]         out_q, out_d, sticky_q, sticky_d, hit;
    logic [NUM_PROPS*CNT_W-1:0]   cnt_q, cnt_d;
    logic [TS_W-1:0]              tstamp_q, tstamp_d, time_q, time_d;
    logic [ID_W-1:0]              id_q, id_d, first_id;
    logic                         valid_q, valid_d, multi_q, multi_d, lost_q, lost_d;
    logic                         seen, many, any_hit, slot_free;

    always_comb begin
        hit      = '0;
        first_id = '0;
        seen     = 1'b0;
        many     = 1'b0;
        for (int unsigned i = 0; i < NUM_PROPS; i++) begin
            hit[i] = run & prop_en[i] & (|rpt_in[i*NUM_REPORTS +: NUM_REPORTS])
                     & (state_q == ACTIVE) & ~clear;
            if (hit[i]) begin
                if (!seen) first_id = ID_W'(i);
                else       many     = 1'b1;
                seen = 1'b1;
            end
        end
        any_hit   = seen;
        slot_free = ~valid_q | evt_ready;
    end

    always_comb begin
        state_d  = state_q;
        out_d    = hit;
        sticky_d = sticky_q | hit;
        cnt_d    = cnt_q;
        tstamp_d = tstamp_q;
        valid_d  = valid_q & ~evt_ready;
        id_d     = id_q;
        time_d   = time_q;
        multi_d  = multi_q;
        lost_d   = lost_q;
        for (int unsigned i = 0; i < NUM_PROPS; i++) begin
            if (hit[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
        if (run && state_q == ACTIVE) tstamp_d = tstamp_q + TS_W'(1);
        // the event is sampled with the pre-increment timestamp
        if (any_hit) begin
            if (slot_free) begin
                valid_d = 1'b1;
                id_d    = first_id;
                time_d  = tstamp_q;
                multi_d = many;
            end else begin
                lost_d  = 1'b1;
            end
            if (FREEZE_ON_VIOL != 0) state_d = FROZEN;
        end
        if (clear) begin
            state_d  = ACTIVE;
            out_d    = '0;
            sticky_d = '0;
            cnt_d    = '0;
            tstamp_d = '0;
            valid_d  = 1'b0;
            multi_d  = 1'b0;
            lost_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ACTIVE;
            out_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
            tstamp_q <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            time_q   <= '0;
            multi_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            tstamp_q <= tstamp_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            time_q   <= time_d;
            multi_q  <= multi_d;
            lost_q   <= lost_d;
        end
    end

    assign ltl_out    = out_q;
    assign ltl_sticky = sticky_q;
    assign viol_cnt   = cnt_q;
    assign evt_valid  = valid_q;
    assign evt_id     = id_q;
    assign evt_time   = time_q;
    assign evt_multi  = multi_q;
    assign evt_lost   = lost_q;
    assign frozen     = (state_q == FROZEN);

endmodule

// File: tb/tb_ltl_monitor_cluster_ctrl.sv
// Bench: two instances (free-running and freeze-on-violation) share stimulus and are
// compared every cycle against an event-level reference model, plus directed literal checks.
module tb_ltl_monitor_cluster_ctrl;

    localparam int NP = 10;
    localparam int NR = 4;
    localparam int CW = 8;
    localparam int TW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset, run, clear, evt_ready;
    logic [NP-1:0]    prop_en;
    logic [NP*NR-1:0] rpt_in;

    logic [NP-1:0]    ltl_o [2];
    logic [NP-1:0]    stk_o [2];
    logic [NP*CW-1:0] cnt_o [2];
    logic [IW-1:0]    id_o  [2];
    logic [TW-1:0]    tim_o [2];
    logic             val_o [2];
    logic             mul_o [2];
    logic             lst_o [2];
    logic             frz_o [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ltl_monitor_cluster_ctrl #(.NUM_PROPS(NP), .NUM_REPORTS(NR), .CNT_W(CW), .TS_W(TW),
                               .FREEZE_ON_VIOL(0)) u_free (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .prop_en(prop_en),
        .rpt_in(rpt_in), .ltl_out(ltl_o[0]), .ltl_sticky(stk_o[0]), .viol_cnt(cnt_o[0]),
        .evt_valid(val_o[0]), .evt_ready(evt_ready), .evt_id(id_o[0]), .evt_time(tim_o[0]),
        .evt_multi(mul_o[0]), .evt_lost(lst_o[0]), .frozen(frz_o[0]));

    ltl_monitor_cluster_ctrl #(.NUM_PROPS(NP), .NUM_REPORTS(NR), .CNT_W(CW), .TS_W(TW),
                               .FREEZE_ON_VIOL(1)) u_frz (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .prop_en(prop_en),
        .rpt_in(rpt_in), .ltl_out(ltl_o[1]), .ltl_sticky(stk_o[1]), .viol_cnt(cnt_o[1]),
        .evt_valid(val_o[1]), .evt_ready(evt_ready), .evt_id(id_o[1]), .evt_time(tim_o[1]),
        .evt_multi(mul_o[1]), .evt_lost(lst_o[1]), .frozen(frz_o[1]));

    // reference model state, one set per instance
    bit        m_ltl    [2][NP];
    bit        m_stk    [2][NP];
    int        m_cnt    [2][NP];
    bit        m_val    [2];
    int        m_id     [2];
    logic [TW-1:0] m_ts [2];
    logic [TW-1:0] m_tim[2];
    bit        m_mul    [2];
    bit        m_lst    [2];
    bit        m_frz    [2];

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d expected=%0d t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        for (int i = 0; i < NP; i++) begin
            m_ltl[k][i] = 0; m_stk[k][i] = 0; m_cnt[k][i] = 0;
        end
        m_val[k] = 0; m_id[k] = 0; m_ts[k] = '0; m_tim[k] = '0;
        m_mul[k] = 0; m_lst[k] = 0; m_frz[k] = 0;
    endtask

    task automatic model_step(input int k, input bit fz);
        int nh;
        int first;
        bit h [NP];
        nh = 0;
        first = -1;
        for (int i = 0; i < NP; i++) begin
            h[i] = run && prop_en[i] && (rpt_in[i*NR +: NR] != '0) && !m_frz[k] && !clear;
            if (h[i]) begin
                if (first < 0) first = i;
                nh++;
            end
        end
        if (clear) begin
            for (int i = 0; i < NP; i++) begin
                m_ltl[k][i] = 0; m_stk[k][i] = 0; m_cnt[k][i] = 0;
            end
            m_val[k] = 0; m_mul[k] = 0; m_lst[k] = 0; m_ts[k] = '0; m_frz[k] = 0;
            return;
        end
        for (int i = 0; i < NP; i++) begin
            m_ltl[k][i] = h[i];
            if (h[i]) m_stk[k][i] = 1;
            if (h[i] && m_cnt[k][i] < 255) m_cnt[k][i]++;
        end
        if (nh > 0) begin
            if (!m_val[k] || evt_ready) begin
                m_val[k] = 1; m_id[k] = first; m_tim[k] = m_ts[k]; m_mul[k] = (nh > 1);
            end else begin
                m_lst[k] = 1;
            end
        end else if (m_val[k] && evt_ready) begin
            m_val[k] = 0;
        end
        if (run && !m_frz[k]) m_ts[k] = m_ts[k] + 1;
        if (fz && nh > 0) m_frz[k] = 1;
    endtask

    // every-cycle comparison against the model
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) model_reset(k);
            else        model_step(k, k == 1);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NP; i++) begin
                chk("ltl_out", k, ltl_o[k][i], m_ltl[k][i]);
                chk("ltl_sticky", k, stk_o[k][i], m_stk[k][i]);
                chk("viol_cnt", k, cnt_o[k][i*CW +: CW], m_cnt[k][i]);
            end
            chk("evt_valid", k, val_o[k], m_val[k]);
            chk("evt_lost", k, lst_o[k], m_lst[k]);
            chk("frozen", k, frz_o[k], m_frz[k]);
            if (m_val[k]) begin
                chk("evt_id", k, id_o[k], m_id[k]);
                chk("evt_time", k, tim_o[k], m_tim[k]);
                chk("evt_multi", k, mul_o[k], m_mul[k]);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic hit_prop(input int p, input int r);
        rpt_in = '0;
        rpt_in[p*NR + r] = 1'b1;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; clear = 1'b0; evt_ready = 1'b0;
        prop_en = '1; rpt_in = '0;
        cyc(2);
        chk("reset_valid", 0, val_o[0], 0);
        chk("reset_cnt", 0, cnt_o[0], 0);
        reset = 1'b1;

        // single hit at tstamp 5
        run = 1'b1;
        cyc(5);
        hit_prop(3, 2);
        cyc();
        chk("t1_ltl", 0, ltl_o[0], 10'h008);
        chk("t1_id", 0, id_o[0], 3);
        chk("t1_time", 0, tim_o[0], 5);
        chk("t1_multi", 0, mul_o[0], 0);
        chk("t1_cnt3", 0, cnt_o[0][3*CW +: CW], 1);
        rpt_in = '0;
        cyc();
        chk("t1_ltl_drop", 0, ltl_o[0], 0);
        chk("t1_sticky", 0, stk_o[0], 10'h008);

        // hits while event held are lost
        hit_prop(0, 1);
        cyc();
        chk("t3_lost", 0, lst_o[0], 1);
        chk("t3_id_held", 0, id_o[0], 3);
        rpt_in = '0; evt_ready = 1'b1;
        cyc();
        chk("t3_drain", 0, val_o[0], 0);

        // simultaneous hits with ready
        rpt_in = '0; rpt_in[1*NR] = 1'b1; rpt_in[6*NR+3] = 1'b1;
        cyc();
        chk("t2_id", 0, id_o[0], 1);
        chk("t2_multi", 0, mul_o[0], 1);
        chk("t2_cnt6", 0, cnt_o[0][6*CW +: CW], 1);

        // saturation, then clear dominates a coincident hit
        rpt_in = '0; clear = 1'b1;
        cyc();
        clear = 1'b0;
        hit_prop(4, 0);
        cyc(300);
        chk("t4_sat", 0, cnt_o[0][4*CW +: CW], 255);
        clear = 1'b1;
        cyc();
        chk("t4_clear_cnt", 0, cnt_o[0], 0);
        chk("t4_clear_stk", 0, stk_o[0], 0);
        clear = 1'b0; rpt_in = '0; evt_ready = 1'b0;

        // freeze instance: hit at t=10, then frozen
        cyc(10);
        hit_prop(7, 0);
        cyc();
        chk("t5_frozen", 1, frz_o[1], 1);
        chk("t5_time", 1, tim_o[1], 10);
        cyc(3);
        chk("t5_ignored", 1, cnt_o[1][7*CW +: CW], 1);
        rpt_in = '0; clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t5_unfrozen", 1, frz_o[1], 0);
        hit_prop(1, 0);
        cyc();
        chk("t5_ts_zero", 1, tim_o[1], 0);

        // disabled property and run=0 produce nothing
        rpt_in = '0; clear = 1'b1;
        cyc();
        clear = 1'b0; prop_en = ~10'h004;
        hit_prop(2, 3);
        cyc();
        chk("t6_disabled", 0, ltl_o[0], 0);
        prop_en = '1; run = 1'b0;
        cyc();
        chk("t6_norun", 0, val_o[0], 0);
        run = 1'b1;
        cyc();
        chk("t6_evt", 0, val_o[0], 1);
        reset = 1'b0;
        #1;
        chk("t6_async_rst", 0, val_o[0], 0);
        chk("t6_async_rst", 1, val_o[1], 0);
        cyc();
        reset = 1'b1; rpt_in = '0;

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            run       = ($urandom_range(9) != 0);
            clear     = ($urandom_range(49) == 0);
            evt_ready = $urandom_range(1);
            prop_en   = ($urandom_range(3) == 0) ? NP'($urandom) : '1;
            for (int b = 0; b < NP*NR; b++) rpt_in[b] = ($urandom_range(23) == 0);
            if ($urandom_range(199) == 0) reset = 1'b0;
            else                          reset = 1'b1;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
